// File: rtl/truth_table_checker.sv
// ============================================================================
// Module  : truth_table_checker
// Brief   : Exhaustive sweep of an N_IN-input combinational DUT against a truth table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module truth_table_checker #(
    parameter int unsigned              N_IN     = 3,
    parameter logic [(1 << N_IN)-1:0]   EXPECTED = 8'h31,
    parameter int unsigned              SETTLE   = 2,
    parameter int unsigned              ERR_W    = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [N_IN-1:0]   vec_o,
    input  logic              dut_y_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    localparam int unsigned     C_SW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [C_SW-1:0] C_SAMPLE_CNT = C_SW'(SETTLE - 1);
    localparam logic [N_IN-1:0] C_LAST_VEC   = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [N_IN-1:0]   r_vec, w_vec_nxt;
    logic [C_SW-1:0]   r_settle, w_settle_nxt;
    logic [ERR_W-1:0]  r_err, w_err_nxt;
    logic [N_IN-1:0]   r_ffv, w_ffv_nxt;
    logic              r_ffvalid, w_ffvalid_nxt;
    logic              w_mismatch;

    assign w_mismatch = (dut_y_i != EXPECTED[r_vec]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_vec     <= '0;
            r_settle  <= '0;
            r_err     <= '0;
            r_ffv     <= '0;
            r_ffvalid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vec     <= w_vec_nxt;
            r_settle  <= w_settle_nxt;
            r_err     <= w_err_nxt;
            r_ffv     <= w_ffv_nxt;
            r_ffvalid <= w_ffvalid_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_vec_nxt     = r_vec;
        w_settle_nxt  = r_settle;
        w_err_nxt     = r_err;
        w_ffv_nxt     = r_ffv;
        w_ffvalid_nxt = r_ffvalid;
        case (r_state)
            S_IDLE, S_DONE: begin
                // A new start clears all results on the accepting edge.
                if (start) begin
                    w_state_nxt   = S_APPLY;
                    w_vec_nxt     = '0;
                    w_settle_nxt  = '0;
                    w_err_nxt     = '0;
                    w_ffv_nxt     = '0;
                    w_ffvalid_nxt = 1'b0;
                end
            end
            S_APPLY: begin
                w_settle_nxt = r_settle + C_SW'(1);
                if (r_settle == C_SAMPLE_CNT) begin
                    if (w_mismatch) begin
                        if (r_err != '1) begin
                            w_err_nxt = r_err + ERR_W'(1);
                        end
                        if (!r_ffvalid) begin
                            w_ffv_nxt     = r_vec;
                            w_ffvalid_nxt = 1'b1;
                        end
                    end
                    w_settle_nxt = '0;
                    // The last vector ends the sweep; vec_o keeps its value.
                    if (r_vec == C_LAST_VEC) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_vec_nxt = r_vec + N_IN'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign vec_o            = r_vec;
    assign busy             = (r_state == S_APPLY);
    assign done             = (r_state == S_DONE);
    assign pass             = done & ~|r_err;
    assign err_count        = r_err;
    assign first_fail_vec   = r_ffv;
    assign first_fail_valid = r_ffvalid;

endmodule

`default_nettype wire
